// File: rtl/imem_ctrl.sv
// Instruction-memory sequencer: zero-fills the RAM after reset, then arbitrates
// the single RAM port between fetch reads and loader writes.
module imem_ctrl #(
  parameter int DEPTH  = 512,
  parameter int AW     = 9,
  parameter int STARVE = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_gnt,
  output logic          f_valid,
  output logic [31:0]   f_ins,
  input  logic          ld_req,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_data,
  output logic          ld_gnt,
  output logic          busy,
  output logic          err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          state_dbg
);

  // Handshake: a requester holds req/addr/data until it sees its gnt in the
  // same cycle; each grant consumes exactly one request cycle.
  localparam int SW = $clog2(STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  logic [AW-1:0] clr_cnt;
  logic [SW-1:0] starve_cnt;
  logic          rd_ok;
  logic [31:0]   ins_hold;
  logic          f_ok;
  logic          ld_ok;
  logic          ld_win;

  assign state_dbg = (state == RUN);
  assign f_ok      = (f_addr < 32'(DEPTH));
  assign ld_ok     = (ld_addr < 32'(DEPTH));

  // Loader wins unless fetch has already waited out STARVE loader grants.
  always_comb begin
    ld_win    = ld_req && !(f_req && (starve_cnt == STARVE_MAX));
    ld_gnt    = 1'b0;
    f_gnt     = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = clr_cnt;
    end else if (ld_win) begin
      ld_gnt    = 1'b1;
      mem_we    = ld_ok;
      mem_addr  = ld_addr[AW-1:0];
      mem_wdata = ld_data;
    end else if (f_req) begin
      f_gnt    = 1'b1;
      mem_addr = f_addr[AW-1:0];
    end
  end

  // Read data arrives in the cycle after the grant, so f_ins is steered
  // straight from the RAM while f_valid is high and held afterwards.
  always_comb begin
    f_ins = ins_hold;
    if (f_valid) f_ins = rd_ok ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      starve_cnt <= '0;
      busy       <= 1'b1;
      err        <= 1'b0;
      f_valid    <= 1'b0;
      rd_ok      <= 1'b0;
      ins_hold   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          if (!f_req || f_gnt) starve_cnt <= '0;
          else if (ld_gnt)     starve_cnt <= starve_cnt + 1'b1;
          if ((ld_gnt && !ld_ok) || (f_gnt && !f_ok)) err <= 1'b1;
        end
        default: state <= CLEAR;
      endcase
      f_valid <= f_gnt;
      rd_ok   <= f_ok;
      if (f_valid) ins_hold <= f_ins;
    end
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// Bench for imem_ctrl: synchronous RAM model, reference memory image and
// arbitration rules evaluated per cycle from the request/grant history.
module tb_imem_ctrl;
  localparam int DEPTH  = 512;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, ld_req;
  logic [31:0] f_addr, ld_addr, ld_data;
  logic        f_gnt, f_valid, ld_gnt, busy, err, mem_we, state_dbg;
  logic [31:0] f_ins, mem_wdata, mem_rdata;
  logic [8:0]  mem_addr;

  logic [31:0] ram     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  imem_ctrl #(.DEPTH(DEPTH), .AW(9), .STARVE(STARVE)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_ins(f_ins),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_gnt(ld_gnt),
    .busy(busy), .err(err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .state_dbg(state_dbg)
  );

  // clock / RAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; f_req = 1'b0; ld_req = 1'b0;
    f_addr = '0; ld_addr = '0; ld_data = '0;
    repeat (3) next_cycle();
    total++; if (busy !== 1'b1 || f_valid !== 1'b0 || err !== 1'b0 || f_ins !== 32'h0) begin
      bad++; $display("FAIL reset_state got busy=%b f_valid=%b err=%b f_ins=%h exp 1 0 0 0", busy, f_valid, err, f_ins);
    end
    // requests held high from release must be ignored through the clear
    f_req = 1'b1; ld_req = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #2;
      total++; if (busy !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 9'(i) || mem_wdata !== 32'h0
                   || f_gnt !== 1'b0 || ld_gnt !== 1'b0) begin
        bad++; $display("FAIL clear_cycle_%0d got busy=%b we=%b addr=%0d wdata=%h fg=%b lg=%b exp addr=%0d", i, busy, mem_we, mem_addr, mem_wdata, f_gnt, ld_gnt, i);
      end
      next_cycle();
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    #2;
    total++; if (busy !== 1'b0 || err !== 1'b0 || ld_gnt !== 1'b1 || f_gnt !== 1'b0) begin
      bad++; $display("FAIL first_grant got busy=%b err=%b lg=%b fg=%b exp 0 0 1 0", busy, err, ld_gnt, f_gnt);
    end
    next_cycle();
    f_req = 1'b0; ld_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_fetch_after_load();
    ld_req = 1'b1; ld_addr = 32'd5; ld_data = 32'h0050_0093;
    #2;
    total++; if (ld_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 9'd5 || mem_wdata !== 32'h0050_0093) begin
      bad++; $display("FAIL load_write got lg=%b we=%b addr=%0d wdata=%h exp 1 1 5 00500093", ld_gnt, mem_we, mem_addr, mem_wdata);
    end
    ref_mem[5] = 32'h0050_0093;
    next_cycle();
    ld_req = 1'b0; f_req = 1'b1; f_addr = 32'd5;
    #2;
    total++; if (f_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 9'd5) begin
      bad++; $display("FAIL fetch_grant got fg=%b we=%b addr=%0d exp 1 0 5", f_gnt, mem_we, mem_addr);
    end
    next_cycle();
    f_req = 1'b0;
    #2;
    total++; if (f_valid !== 1'b1 || f_ins !== 32'h0050_0093) begin
      bad++; $display("FAIL fetch_data got v=%b ins=%h exp 1 00500093", f_valid, f_ins);
    end
    next_cycle();
    #2;
    total++; if (f_valid !== 1'b0 || f_ins !== 32'h0050_0093 || mem_addr !== 9'd0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL fetch_hold got v=%b ins=%h addr=%0d we=%b exp 0 00500093 0 0", f_valid, f_ins, mem_addr, mem_we);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    logic exp_f;
    f_req = 1'b1; f_addr = 32'd5;
    ld_req = 1'b1;
    for (int i = 0; i < 15; i++) begin
      ld_addr = 32'(100 + i); ld_data = $urandom;
      #2;
      exp_f = ((i % 5) == 4);
      total++; if (f_gnt !== exp_f || ld_gnt !== !exp_f) begin
        bad++; $display("FAIL contention_%0d got fg=%b lg=%b exp fg=%b", i, f_gnt, ld_gnt, exp_f);
      end
      total++; if (f_valid !== (i > 0 && ((i - 1) % 5) == 4)) begin
        bad++; $display("FAIL contention_valid_%0d got v=%b", i, f_valid);
      end else if (f_valid && f_ins !== ref_mem[5]) begin
        bad++; $display("FAIL contention_ins_%0d got %h exp %h", i, f_ins, ref_mem[5]);
      end
      if (!exp_f) ref_mem[100 + i] = ld_data;
      next_cycle();
    end
    f_req = 1'b0; ld_req = 1'b0;
    #2;
    total++; if (f_valid !== 1'b1 || f_ins !== ref_mem[5]) begin
      bad++; $display("FAIL contention_drain got v=%b ins=%h exp 1 %h", f_valid, f_ins, ref_mem[5]);
    end
    next_cycle();
  endtask

  task automatic test_random(input int n);
    int   waited = 0;
    logic exp_f, exp_l;
    logic [31:0] want;
    exp_q.delete();
    for (int c = 0; c <= n; c++) begin
      if (c < n && !f_req && $urandom_range(0, 99) < 60) begin
        f_req = 1'b1; f_addr = $urandom_range(0, DEPTH - 1);
      end
      if (c < n && !ld_req && $urandom_range(0, 99) < 55) begin
        ld_req = 1'b1; ld_addr = $urandom_range(0, DEPTH - 1); ld_data = $urandom;
      end
      #2;
      exp_f = f_req && (!ld_req || waited == STARVE);
      exp_l = ld_req && !exp_f;
      total++; if (f_gnt !== exp_f || ld_gnt !== exp_l || mem_we !== exp_l) begin
        bad++; $display("FAIL rand_grant_%0d got fg=%b lg=%b we=%b exp %b %b %b", c, f_gnt, ld_gnt, mem_we, exp_f, exp_l, exp_l);
      end
      total++; if ((exp_l && (mem_addr !== ld_addr[8:0] || mem_wdata !== ld_data))
                   || (exp_f && mem_addr !== f_addr[8:0]) || (!exp_l && !exp_f && mem_addr !== 9'd0)) begin
        bad++; $display("FAIL rand_addr_%0d got addr=%0d wdata=%h", c, mem_addr, mem_wdata);
      end
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        total++; if (f_valid !== 1'b1 || f_ins !== want) begin
          bad++; $display("FAIL rand_read_%0d got v=%b ins=%h exp 1 %h", c, f_valid, f_ins, want);
        end
      end else begin
        total++; if (f_valid !== 1'b0) begin
          bad++; $display("FAIL rand_novalid_%0d got v=%b exp 0", c, f_valid);
        end
      end
      total++; if (err !== 1'b0) begin
        bad++; $display("FAIL rand_err_%0d got %b exp 0", c, err);
      end
      if (exp_f) exp_q.push_back(ref_mem[f_addr[8:0]]);
      if (exp_l) ref_mem[ld_addr[8:0]] = ld_data;
      waited = (f_req && exp_l) ? waited + 1 : 0;
      next_cycle();
      if (exp_f) f_req = 1'b0;
      if (exp_l) ld_req = 1'b0;
    end
    f_req = 1'b0; ld_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_out_of_range();
    f_req = 1'b1; f_addr = 32'd600;
    #2;
    total++; if (f_gnt !== 1'b1) begin
      bad++; $display("FAIL oor_fetch_gnt got %b exp 1", f_gnt);
    end
    next_cycle();
    f_req = 1'b0; ld_req = 1'b1; ld_addr = 32'd512; ld_data = 32'hdead_beef;
    #2;
    total++; if (f_valid !== 1'b1 || f_ins !== 32'h0 || err !== 1'b1) begin
      bad++; $display("FAIL oor_fetch_resp got v=%b ins=%h err=%b exp 1 0 1", f_valid, f_ins, err);
    end
    total++; if (ld_gnt !== 1'b1 || mem_we !== 1'b0) begin
      bad++; $display("FAIL oor_load got lg=%b we=%b exp 1 0", ld_gnt, mem_we);
    end
    next_cycle();
    ld_addr = 32'd511; ld_data = 32'h0000_1234;
    #2;
    total++; if (ld_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 9'd511 || err !== 1'b1) begin
      bad++; $display("FAIL edge_load got lg=%b we=%b addr=%0d err=%b exp 1 1 511 1", ld_gnt, mem_we, mem_addr, err);
    end
    ref_mem[511] = 32'h0000_1234;
    next_cycle();
    ld_req = 1'b0; f_req = 1'b1; f_addr = 32'h8000_0005;
    next_cycle();
    f_addr = 32'd0;
    #2;
    total++; if (f_valid !== 1'b1 || f_ins !== 32'h0) begin
      bad++; $display("FAIL oor_high_bits got v=%b ins=%h exp 1 0", f_valid, f_ins);
    end
    next_cycle();
    f_addr = 32'd511;
    #2;
    total++; if (f_valid !== 1'b1 || f_ins !== ref_mem[0]) begin
      bad++; $display("FAIL addr0_intact got ins=%h exp %h", f_ins, ref_mem[0]);
    end
    next_cycle();
    f_req = 1'b0;
    #2;
    total++; if (f_valid !== 1'b1 || f_ins !== 32'h0000_1234 || err !== 1'b1) begin
      bad++; $display("FAIL edge_fetch got v=%b ins=%h err=%b exp 1 00001234 1", f_valid, f_ins, err);
    end
    next_cycle();
  endtask

  task automatic test_midrun_reset();
    ld_req = 1'b1; ld_addr = 32'd5; ld_data = 32'h0050_0093;
    next_cycle();
    ld_req = 1'b0; f_req = 1'b1; f_addr = 32'd5;
    next_cycle();
    f_req = 1'b0;
    rst = 1'b0;
    #1;
    total++; if (f_valid !== 1'b0 || busy !== 1'b1 || f_ins !== 32'h0 || err !== 1'b0) begin
      bad++; $display("FAIL midrun_async got v=%b busy=%b ins=%h err=%b exp 0 1 0 0", f_valid, busy, f_ins, err);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #2;
      total++; if (busy !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 9'(i) || mem_wdata !== 32'h0) begin
        bad++; $display("FAIL reclear_%0d got busy=%b we=%b addr=%0d wdata=%h", i, busy, mem_we, mem_addr, mem_wdata);
      end
      next_cycle();
    end
    f_req = 1'b1; f_addr = 32'd5;
    #2;
    total++; if (f_gnt !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reclear_fetch got fg=%b busy=%b exp 1 0", f_gnt, busy);
    end
    next_cycle();
    f_req = 1'b0;
    #2;
    total++; if (f_valid !== 1'b1 || f_ins !== 32'h0) begin
      bad++; $display("FAIL reclear_word5 got v=%b ins=%h exp 1 0", f_valid, f_ins);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_fetch_after_load();
    test_contention();
    test_random(400);
    test_out_of_range();
    test_midrun_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_ctrl.md
# imem_ctrl

Sequencer and arbiter for the CPU's 512-word instruction memory. After reset it zero-fills the whole array one word per cycle. It then shares the single memory port between the fetch unit (reads) and the program loader (writes). It sits between fetch/loader and a synchronous-read, single-port word RAM, so the memory array itself carries no reset or clear logic.

## Interface
Parameters:
- DEPTH, 512, number of 32-bit words in the memory
- AW, 9, memory address width (log2 DEPTH)
- STARVE, 4, maximum consecutive loader grants while fetch is waiting

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- f_req  in  1  fetch request
- f_addr  in  32  fetch word address (pc >> 2)
- f_gnt  out  1  fetch accepted this cycle (combinational)
- f_valid  out  1  f_ins is valid (registered)
- f_ins  out  32  fetched instruction
- ld_req  in  1  loader write request
- ld_addr  in  32  loader word address
- ld_data  in  32  loader write data
- ld_gnt  out  1  loader write accepted this cycle (combinational)
- busy  out  1  clear sequence in progress
- err  out  1  sticky: an out-of-range address was granted
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid one cycle after the address is presented

## Operation
- FSM states: CLEAR and RUN.
- Reset (rst=0, asynchronous) forces:
  - state=CLEAR, clr_cnt=0, starve_cnt=0
  - f_valid=0, f_ins=0, err=0, busy=1
- CLEAR state:
  - Drives mem_we=1, mem_addr=clr_cnt, mem_wdata=0; clr_cnt increments each cycle.
  - f_gnt=0 and ld_gnt=0; all requests are ignored.
  - When clr_cnt=DEPTH-1 the write still happens, and the next state is RUN.
- RUN state, arbitration per cycle:
  - Loader has priority.
  - Exception: if f_req=1 and starve_cnt=STARVE, fetch is granted instead and starve_cnt clears.
  - starve_cnt increments on each ld_gnt issued while f_req=1.
  - starve_cnt clears whenever f_req=0 or f_gnt=1.
- Loader grant: mem_we=1, mem_addr=ld_addr[AW-1:0], mem_wdata=ld_data.
- Fetch grant: mem_we=0, mem_addr=f_addr[AW-1:0].
- No grant: mem_we=0, mem_addr=0.
- Range check: an address is in range iff addr < DEPTH (upper bits zero).
  - Out-of-range loader grant: write is suppressed (mem_we=0), err is set.
  - Out-of-range fetch grant: err is set, and the response returns f_ins=0.
- Read return:
  - A registered flag records that a fetch was granted and whether it was in range.
  - On the next cycle f_valid=1, and f_ins is mem_rdata (in range) or 0 (out of range).
  - f_ins holds its value while f_valid=0.
- err clears only on reset.

## Timing
- Clear duration: exactly DEPTH cycles after reset deasserts. With DEPTH=512, busy falls on edge 512, and the first grant is possible in cycle 512 (0-based).
- Fetch latency: f_gnt in cycle N gives f_valid=1 in cycle N+1 only. Back-to-back grants give back-to-back f_valid.
- Handshake: a requester must hold req and its addr/data stable until it sees its gnt in the same cycle. A grant consumes exactly one request cycle.
- Same-address hazard: a loader write in cycle N is visible to a fetch granted in cycle N+1 or later. Both cannot be granted in the same cycle.
- Reset mid-operation:
  - Asynchronously drops f_valid and any in-flight read.
  - The clear restarts from address 0.
  - Partially loaded contents are overwritten with zeros.
- Reset during CLEAR restarts the count at 0.

## Test plan
- Reset clear: hold rst=0 for 3 cycles, then release. Required: busy=1 for 512 cycles; mem_we=1 with addresses 0..511 in order, all data 0; then busy=0 and err=0.
- Fetch after load: loader writes 0x00500093 to addr 5. Then fetch f_addr=5. Required: f_gnt in cycle N; f_valid=1 and f_ins=0x00500093 in cycle N+1.
- Contention and starvation guard: ld_req and f_req held high continuously (STARVE=4). Required grant pattern: ld,ld,ld,ld,f,ld,ld,ld,ld,f,...
- Out of range: fetch f_addr=600. Required: f_valid=1 with f_ins=0 next cycle; err=1 and stays 1. Loader ld_addr=512: mem_we=0, ld_gnt=1.
- Requests during clear: f_req=1 and ld_req=1 from reset release. Required: no grants for 512 cycles; first grant goes to the loader in cycle 512.
- Mid-run reset: assert rst for one cycle while f_valid would be 1. Required: f_valid=0 immediately; busy=1; clear restarts at mem_addr=0; previously loaded word 5 reads 0 after re-clear.
